cam_capture_axis: RTL



---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_capture_axis_pack.sv | 79 +++++++
 rtl/cam_capture_axis.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path.
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active frame geometry
//   cam_state_e                 : capture FSM state encoding
//   rgb565_to_rgb888            : widens a packed 565 pixel to 8 bits per channel
package cam_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } cam_state_e;

  // Each channel is widened by repeating its top bits into the new LSBs, so
  // full scale maps to 0xFF and zero stays zero.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = p[15:11];
    g6 = p[10:5];
    b5 = p[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/cam_capture_axis_pack.sv
// Byte-pair assembler: joins two camera bytes into one RGB888 pixel and
// tracks the pixel position within the current line.
//   Cclk, rstn   : pixel clock, async active-low reset
//   en_i         : a byte of an active line is present on byte_i
//   start_i      : a new frame begins (arms the first-pixel marker)
//   byte_i       : registered camera byte
//   pix_valid_o  : a pixel inside the active width completes this cycle
//   pix_data_o   : expanded {R8,G8,B8}
//   pix_first_o  : pixel is the first of the frame
//   pix_last_o   : pixel is the last of the line
//   pix_long_o   : a pixel beyond the active width completed (dropped)
//   pix_cnt_o    : pixels accepted so far on this line
module cam_capture_axis_pack
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        en_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  output logic        pix_valid_o,
  output logic [23:0] pix_data_o,
  output logic        pix_first_o,
  output logic        pix_last_o,
  output logic        pix_long_o,
  output logic [9:0]  pix_cnt_o
);

  localparam logic [9:0] H_MAX  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);

  logic       phase_q, phase_d;
  logic [7:0] hi_q;
  logic [9:0] pix_cnt_q, pix_cnt_d;
  logic       first_q, first_d;
  logic       done, keep;

  // A pixel completes on the second byte; once the line is full the count
  // saturates at H_ACTIVE so any further pixel is recognised as overlong.
  assign done        = en_i && phase_q;
  assign keep        = (pix_cnt_q < H_MAX);
  assign pix_valid_o = done && keep;
  assign pix_long_o  = done && !keep;
  assign pix_data_o  = rgb565_to_rgb888({hi_q, byte_i});
  assign pix_first_o = first_q;
  assign pix_last_o  = (pix_cnt_q == H_LAST);
  assign pix_cnt_o   = pix_cnt_q;

  always_comb begin
    phase_d   = en_i ? ~phase_q : 1'b0;
    pix_cnt_d = pix_cnt_q;
    if (!en_i)            pix_cnt_d = '0;
    else if (pix_valid_o) pix_cnt_d = pix_cnt_q + 10'd1;
    first_d = first_q;
    if (start_i)          first_d = 1'b1;
    else if (pix_valid_o) first_d = 1'b0;
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      phase_q   <= 1'b0;
      pix_cnt_q <= '0;
      first_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pix_cnt_q <= pix_cnt_d;
      first_q   <= first_d;
    end
  end

  // First byte of the pair; a stale value after an odd byte is never used
  // because the phase restarts at 0 on every new line.
  always_ff @(posedge Cclk) begin
    if (en_i && !phase_q) hi_q <= byte_i;
  end

endmodule

// File: rtl/cam_capture_axis.sv
// Camera parallel bus (VSYNC/HREF/8-bit RGB565) to 24-bit AXI4-Stream video.
//   Cclk, rstn          : camera pixel clock, async active-low reset
//   cam_vsync/href/data : raw sensor bus
//   capture_en          : capture the next frame (decided at vsync end)
//   err_clr             : pulse clearing the sticky error flags
//   m_axis_video_*      : AXI4-Stream master, tuser = start of frame,
//                         tlast = end of line
//   frame_cnt           : count of correctly sized frames
//   err_short/long/frame/ovf : sticky line, frame and overflow errors
module cam_capture_axis
  import cam_pkg::*;
#(
  parameter int   H_ACTIVE  = H_ACTIVE_DEF,
  parameter int   V_ACTIVE  = V_ACTIVE_DEF,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  input  logic        err_clr,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  input  logic        m_axis_video_tready,
  output logic [15:0] frame_cnt,
  output logic        err_short,
  output logic        err_long,
  output logic        err_frame,
  output logic        err_ovf
);

  localparam logic [9:0] H_MAX   = 10'(H_ACTIVE);
  localparam logic [8:0] V_LINES = 9'(V_ACTIVE);

  logic        vsync_q, href_q;
  logic [7:0]  data_q;
  cam_state_e  state_q;
  logic [8:0]  line_cnt_q, lines_done;
  logic [15:0] frame_cnt_q;
  logic        vs_act, in_active, pack_en, start, line_end, frame_bad;
  logic        pix_valid, pix_first, pix_last, pix_long;
  logic [23:0] pix_data;
  logic [9:0]  pix_cnt;
  logic        tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
  logic [23:0] tdata_q, tdata_d;
  logic        ovf;
  logic        err_short_q, err_long_q, err_frame_q, err_ovf_q;

  // ---- input register stage ----
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      vsync_q <= ~VSYNC_POL;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
    end
  end

  always_ff @(posedge Cclk) data_q <= cam_data;

  assign vs_act    = (vsync_q == VSYNC_POL);
  assign in_active = (state_q == ACTIVE);
  // vsync during href aborts the line: the packer is disabled, dropping any
  // half pixel and clearing its count.
  assign pack_en   = in_active && href_q && !vs_act;
  assign start     = (state_q == SYNC) && !vs_act && capture_en;
  assign line_end  = in_active && !href_q && (pix_cnt != '0);
  // Counts a line ending in the very cycle vsync is seen.
  assign lines_done = line_cnt_q + 9'(line_end);
  assign frame_bad  = in_active && vs_act && (href_q || (lines_done != V_LINES));

  cam_capture_axis_pack #(.H_ACTIVE(H_ACTIVE)) u_pack (
    .Cclk        (Cclk),
    .rstn        (rstn),
    .en_i        (pack_en),
    .start_i     (start),
    .byte_i      (data_q),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data),
    .pix_first_o (pix_first),
    .pix_last_o  (pix_last),
    .pix_long_o  (pix_long),
    .pix_cnt_o   (pix_cnt)
  );

  // ---- frame FSM and line/frame counters ----
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (vs_act) state_q <= SYNC;
        SYNC: if (!vs_act) begin
          state_q    <= capture_en ? ACTIVE : IDLE;
          line_cnt_q <= '0;
        end
        ACTIVE: begin
          if (line_end) line_cnt_q <= line_cnt_q + 9'd1;
          if (vs_act) begin
            state_q <= SYNC;
            if (!frame_bad) frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- output register (one-entry skid-less slot) ----
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (pix_valid && (!tvalid_q || m_axis_video_tready)) begin
      tvalid_d = 1'b1;
      tdata_d  = pix_data;
      tuser_d  = pix_first;
      tlast_d  = pix_last;
    end else if (tvalid_q && m_axis_video_tready) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  assign ovf = pix_valid && tvalid_q && !m_axis_video_tready;

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_frame_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      // A new error in the clear cycle wins over the clear.
      err_short_q <= (err_short_q && !err_clr) || (line_end && (pix_cnt < H_MAX));
      err_long_q  <= (err_long_q  && !err_clr) || pix_long;
      err_frame_q <= (err_frame_q && !err_clr) || frame_bad;
      err_ovf_q   <= (err_ovf_q   && !err_clr) || ovf;
    end
  end

  assign m_axis_video_tdata  = tdata_q;
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tuser  = tuser_q;
  assign m_axis_video_tlast  = tlast_q;
  assign frame_cnt           = frame_cnt_q;
  assign err_short           = err_short_q;
  assign err_long            = err_long_q;
  assign err_frame           = err_frame_q;
  assign err_ovf             = err_ovf_q;

endmodule
